// File: rtl/alp_param_core_if.sv
// Command/load/result bundle for the parametrised ALP core.
// Latency: none, pure wiring between the driver and the core.
// Backpressure: commands are only honoured while the core reports o_BUSY=0.
interface alp_param_core_if #(
  parameter int WIDTH = 4
);
  logic [2:0]       i_OP;
  logic [WIDTH-1:0] i_DATA_IN;
  logic             i_LOAD;
  logic             i_COMP;
  logic             i_CLR;
  logic [WIDTH-1:0] o_R0;
  logic [WIDTH-1:0] o_R1;
  logic             o_BUSY;
  logic             o_DONE;
  logic             o_ERR;

  modport master (
    output i_OP, i_DATA_IN, i_LOAD, i_COMP, i_CLR,
    input  o_R0, o_R1, o_BUSY, o_DONE, o_ERR
  );

  modport slave (
    input  i_OP, i_DATA_IN, i_LOAD, i_COMP, i_CLR,
    output o_R0, o_R1, o_BUSY, o_DONE, o_ERR
  );
endinterface

// File: rtl/alp_param_core.sv
// Two-register signed ALU: add/sub/neg/cmp/swap, Booth multiply, restoring divide (ALP_DIV_EN builds divider).
// Latency: 1 edge for single-cycle ops, WIDTH edges for MUL, WIDTH+1 edges for DIV; DONE pulses on completion.
// Backpressure: i_COMP/i_LOAD ignored while o_BUSY=1; i_CLR aborts any operation at the next edge.
module alp_param_core #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            i_rst,
  alp_param_core_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IT = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_NEG  = 3'b100;
  localparam logic [2:0] OP_CMP  = 3'b101;
  localparam logic [2:0] OP_SWAP = 3'b110;

`ifdef ALP_DIV_EN
  localparam logic [2:0] OP_DIV  = 3'b011;
  typedef enum logic [1:0] {S_IDLE, S_MUL_IT, S_DIV_IT, S_DIV_FIX} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL_IT} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_r0;
  logic [WIDTH-1:0] r_r1;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  // Shared iterative working set: Booth uses acc/q/q1/m, the divider uses acc/q/m.
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [WIDTH:0]   r_m;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_neg;
  logic [WIDTH-1:0] w_cmp;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_r0_min;

  logic [WIDTH:0]   w_b_sum;
  logic [WIDTH:0]   w_b_acc;
  logic [WIDTH-1:0] w_b_q;
  logic             w_b_q1;

  assign bus.o_R0   = r_r0;
  assign bus.o_R1   = r_r1;
  assign bus.o_BUSY = r_busy;
  assign bus.o_DONE = r_done;
  assign bus.o_ERR  = r_err;

  // Single-cycle arithmetic and signed-overflow detection.
  always_comb begin
    w_add     = r_r0 + r_r1;
    w_sub     = r_r0 - r_r1;
    w_neg     = WIDTH'(0) - r_r0;
    w_r0_min  = (r_r0 == {1'b1, {(WIDTH-1){1'b0}}});
    w_add_ovf = (r_r0[WIDTH-1] == r_r1[WIDTH-1]) && (w_add[WIDTH-1] != r_r0[WIDTH-1]);
    w_sub_ovf = (r_r0[WIDTH-1] != r_r1[WIDTH-1]) && (w_sub[WIDTH-1] != r_r0[WIDTH-1]);
    if ($signed(r_r0) > $signed(r_r1)) begin
      w_cmp = WIDTH'(1);
    end else if (r_r0 == r_r1) begin
      w_cmp = '0;
    end else begin
      w_cmp = '1;
    end
  end

  // One radix-2 Booth step; acc is one bit wider so subtracting MIN cannot overflow.
  always_comb begin
    w_b_sum = r_acc;
    case ({r_q[0], r_q1})
      2'b01:   w_b_sum = r_acc + r_m;
      2'b10:   w_b_sum = r_acc - r_m;
      default: w_b_sum = r_acc;
    endcase
    w_b_acc = {w_b_sum[WIDTH], w_b_sum[WIDTH:1]};
    w_b_q   = {w_b_sum[0], r_q[WIDTH-1:1]};
    w_b_q1  = r_q[0];
  end

`ifdef ALP_DIV_EN
  logic [WIDTH-1:0] w_abs0;
  logic [WIDTH-1:0] w_abs1;
  logic             w_div_bad;
  logic [WIDTH:0]   w_d_sh;
  logic             w_d_ge;
  logic [WIDTH:0]   w_d_acc;
  logic [WIDTH-1:0] w_d_q;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic             r_qneg;
  logic             r_rneg;

  // Magnitude restoring divide step plus the final sign correction.
  always_comb begin
    w_abs0    = r_r0[WIDTH-1] ? (WIDTH'(0) - r_r0) : r_r0;
    w_abs1    = r_r1[WIDTH-1] ? (WIDTH'(0) - r_r1) : r_r1;
    w_div_bad = (r_r1 == '0) || (w_r0_min && (r_r1 == '1));
    w_d_sh    = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    w_d_ge    = (w_d_sh >= r_m);
    w_d_acc   = w_d_ge ? (w_d_sh - r_m) : w_d_sh;
    w_d_q     = {r_q[WIDTH-2:0], w_d_ge};
    w_quot    = r_qneg ? (WIDTH'(0) - r_q) : r_q;
    w_rem     = r_rneg ? (WIDTH'(0) - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  end
`endif

  // Command sequencing FSM with registered outputs; reset and clear both return to IDLE with zeros.
  always_ff @(posedge clk) begin
    if (i_rst || bus.i_CLR) begin
      r_state <= S_IDLE;
      r_r0    <= '0;
      r_r1    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_acc   <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_m     <= '0;
      r_cnt   <= '0;
`ifdef ALP_DIV_EN
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_COMP) begin
            case (bus.i_OP)
              OP_ADD: begin
                r_r0   <= w_add;
                r_err  <= r_err | w_add_ovf;
                r_done <= 1'b1;
              end
              OP_SUB: begin
                r_r0   <= w_sub;
                r_err  <= r_err | w_sub_ovf;
                r_done <= 1'b1;
              end
              OP_MUL: begin
                r_acc   <= '0;
                r_q     <= r_r0;
                r_q1    <= 1'b0;
                r_m     <= {r_r1[WIDTH-1], r_r1};
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= S_MUL_IT;
              end
`ifdef ALP_DIV_EN
              OP_DIV: begin
                if (w_div_bad) begin
                  r_err  <= 1'b1;
                  r_done <= 1'b1;
                end else begin
                  r_acc   <= '0;
                  r_q     <= w_abs0;
                  r_m     <= {1'b0, w_abs1};
                  r_qneg  <= r_r0[WIDTH-1] ^ r_r1[WIDTH-1];
                  r_rneg  <= r_r0[WIDTH-1];
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_DIV_IT;
                end
              end
`endif
              OP_NEG: begin
                if (w_r0_min) begin
                  r_err <= 1'b1;
                end else begin
                  r_r0 <= w_neg;
                end
                r_done <= 1'b1;
              end
              OP_CMP: begin
                r_r0   <= w_cmp;
                r_done <= 1'b1;
              end
              OP_SWAP: begin
                r_r0   <= r_r1;
                r_r1   <= r_r0;
                r_done <= 1'b1;
              end
              default: begin
                r_err  <= 1'b1;
                r_done <= 1'b1;
              end
            endcase
          end else if (bus.i_LOAD) begin
            if (bus.i_OP[0]) begin
              r_r1 <= bus.i_DATA_IN;
            end else begin
              r_r0 <= bus.i_DATA_IN;
            end
          end
        end
        S_MUL_IT: begin
          r_acc <= w_b_acc;
          r_q   <= w_b_q;
          r_q1  <= w_b_q1;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_IT) begin
            r_r0    <= w_b_q;
            r_r1    <= w_b_acc[WIDTH-1:0];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
`ifdef ALP_DIV_EN
        S_DIV_IT: begin
          r_acc <= w_d_acc;
          r_q   <= w_d_q;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_IT) begin
            r_state <= S_DIV_FIX;
          end
        end
        S_DIV_FIX: begin
          r_r0    <= w_quot;
          r_r1    <= w_rem;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
